// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller:
// op codes, FSM state encoding, access sizes and byte-enable constants.
package dmem_ctrl_pkg;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_LB   = 4'b1000;
  localparam logic [3:0] OP_LH   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_LBU  = 4'b1100;
  localparam logic [3:0] OP_LHU  = 4'b1101;
  localparam logic [3:0] OP_SB   = 4'b0101;
  localparam logic [3:0] OP_SH   = 4'b0110;
  localparam logic [3:0] OP_SW   = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  function automatic logic op_is_load(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH: return 1'b1;
      default:      return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane alignment: store replication plus byte enables, and load
// lane extraction plus sign/zero extension. Store and load paths are independent.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [3:0]  st_op_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_byte_en_o,
  input  logic [3:0]  ld_op_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  // Replicate store data across lanes and build byte enables from size/offset.
  always_comb begin
    st_data_o    = st_data_i;
    st_byte_en_o = BE_NONE;
    if (op_is_store(st_op_i)) begin
      case (op_size(st_op_i))
        SZ_BYTE: begin
          st_data_o    = {4{st_data_i[7:0]}};
          st_byte_en_o = BE_BYTE0 << st_addr_i;
        end
        SZ_HALF: begin
          st_data_o    = {2{st_data_i[15:0]}};
          st_byte_en_o = st_addr_i[1] ? BE_HALF_HI : BE_HALF_LO;
        end
        default: begin
          st_data_o    = st_data_i;
          st_byte_en_o = BE_WORD;
        end
      endcase
    end else begin
      st_data_o    = st_data_i;
      st_byte_en_o = BE_NONE;
    end
  end

  // Pick the addressed byte and half-word lanes out of the returned word.
  always_comb begin
    case (ld_addr_i)
      2'd0:    ld_byte_s = ld_rdata_i[7:0];
      2'd1:    ld_byte_s = ld_rdata_i[15:8];
      2'd2:    ld_byte_s = ld_rdata_i[23:16];
      default: ld_byte_s = ld_rdata_i[31:24];
    endcase
    ld_half_s = ld_addr_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];
  end

  // Extend the selected lane according to the load flavour.
  always_comb begin
    ld_data_o = 32'h0000_0000;
    if (op_is_load(ld_op_i)) begin
      case (op_size(ld_op_i))
        SZ_BYTE: ld_data_o = op_is_signed(ld_op_i) ? {{24{ld_byte_s[7]}}, ld_byte_s}
                                                   : {24'h00_0000, ld_byte_s};
        SZ_HALF: ld_data_o = op_is_signed(ld_op_i) ? {{16{ld_half_s[15]}}, ld_half_s}
                                                   : {16'h0000, ld_half_s};
        default: ld_data_o = ld_rdata_i;
      endcase
    end else begin
      ld_data_o = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/dmem_access_controller.sv
// MEM-stage sequencer: one request/response handshake per memory op with a
// bounded wait, a global pipeline stall, and registered memory-side outputs.
module dmem_access_controller
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ALU_RESULT,
  input  logic [31:0] DATA2,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTE_EN,
  output logic        BUSYWAIT,
  output logic [31:0] LOAD_DATA,
  output logic        MISALIGNED,
  output logic        ERROR
);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic        is_ld_q, is_ld_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, load_data_q, load_data_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        misaligned_q, misaligned_d, error_q, error_d;

  logic        rw_mem_op_s, misal_s, req_valid_s, timeout_s, busywait_s;
  logic [31:0] st_data_s, ld_data_s;
  logic [3:0]  st_be_s;

  assign rw_mem_op_s = op_is_load(READ_WRITE) | op_is_store(READ_WRITE);
  assign misal_s     = rw_mem_op_s & is_misaligned(op_size(READ_WRITE), ALU_RESULT[1:0]);
  assign req_valid_s = rw_mem_op_s & ~misal_s;
  assign timeout_s   = MEM_BUSYWAIT & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  dmem_align u_align (
    .st_op_i      (READ_WRITE),
    .st_addr_i    (ALU_RESULT[1:0]),
    .st_data_i    (DATA2),
    .st_data_o    (st_data_s),
    .st_byte_en_o (st_be_s),
    .ld_op_i      (op_q),
    .ld_addr_i    (addr_lo_q),
    .ld_rdata_i   (MEM_READDATA),
    .ld_data_o    (ld_data_s)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: leave IDLE on a legal op, finish ACCESS on ready or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = req_valid_s ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = (!MEM_BUSYWAIT || timeout_s) ? S_DONE : S_ACCESS;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: stall and the next values of all registered outputs.
  always_comb begin
    busywait_s   = 1'b0;
    cnt_d        = cnt_q;
    op_d         = op_q;
    is_ld_d      = is_ld_q;
    addr_lo_d    = addr_lo_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    load_data_d  = load_data_q;
    misaligned_d = 1'b0;
    error_d      = error_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_s) begin
          busywait_s  = 1'b1;
          cnt_d       = '0;
          op_d        = READ_WRITE;
          is_ld_d     = op_is_load(READ_WRITE);
          addr_lo_d   = ALU_RESULT[1:0];
          mem_read_d  = op_is_load(READ_WRITE);
          mem_write_d = op_is_store(READ_WRITE);
          mem_addr_d  = {ALU_RESULT[31:2], 2'b00};
          mem_wdata_d = st_data_s;
          mem_be_d    = st_be_s;
        end else if (misal_s) begin
          misaligned_d = 1'b1;
        end else begin
          misaligned_d = 1'b0;
        end
      end
      S_ACCESS: begin
        busywait_s = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (!MEM_BUSYWAIT) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          load_data_d = is_ld_q ? ld_data_s : load_data_q;
        end else if (timeout_s) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          load_data_d = 32'h0000_0000;
          error_d     = 1'b1;
        end else begin
          mem_read_d  = mem_read_q;
          mem_write_d = mem_write_q;
        end
      end
      S_DONE:  busywait_s = 1'b0;
      default: busywait_s = 1'b0;
    endcase
  end

  // Datapath and output registers; reset abandons any access in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q        <= '0;
      op_q         <= OP_NONE;
      is_ld_q      <= 1'b0;
      addr_lo_q    <= 2'b00;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
      mem_be_q     <= BE_NONE;
      load_data_q  <= 32'h0000_0000;
      misaligned_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      is_ld_q      <= is_ld_d;
      addr_lo_q    <= addr_lo_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      load_data_q  <= load_data_d;
      misaligned_q <= misaligned_d;
      error_q      <= error_d;
    end
  end

  // The stall is released while reset is held so a held op cannot freeze the pipe.
  assign BUSYWAIT      = RESET & busywait_s;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign MEM_BYTE_EN   = mem_be_q;
  assign LOAD_DATA     = load_data_q;
  assign MISALIGNED    = misaligned_q;
  assign ERROR         = error_q;

endmodule

// File: tb/tb_dmem_access_controller.sv
// Directed bench for dmem_access_controller with a transaction-level model.
module tb_dmem_access_controller;

  localparam int TO = 4;
  localparam logic [3:0] T_NONE = 4'b0000, T_LB = 4'b1000, T_LH = 4'b1001, T_LW = 4'b1010,
                         T_LBU = 4'b1100, T_LHU = 4'b1101, T_SB = 4'b0101, T_SH = 4'b0110,
                         T_SW = 4'b0111;

  logic        CLK, RESET, MEM_BUSYWAIT;
  logic [3:0]  READ_WRITE;
  logic [31:0] ALU_RESULT, DATA2, MEM_READDATA;
  logic        MEM_READ, MEM_WRITE, BUSYWAIT, MISALIGNED, ERROR;
  logic [31:0] MEM_ADDRESS, MEM_WRITEDATA, LOAD_DATA;
  logic [3:0]  MEM_BYTE_EN;

  dmem_access_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ALU_RESULT(ALU_RESULT),
    .DATA2(DATA2), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_BYTE_EN(MEM_BYTE_EN), .BUSYWAIT(BUSYWAIT),
    .LOAD_DATA(LOAD_DATA), .MISALIGNED(MISALIGNED), .ERROR(ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  // Model expectations for the current cycle.
  logic        exp_busy = 1'b0, exp_read = 1'b0, exp_write = 1'b0, exp_misal = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_load = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
  logic [3:0]  exp_be = 4'h0;

  // Observation counters and last write attributes, taken from the DUT.
  int busy_cycles, read_cycles, write_cycles, misal_cycles;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int op_bytes(input logic [3:0] op);
    case (op)
      T_LB, T_LBU, T_SB: return 1;
      T_LH, T_LHU, T_SH: return 2;
      T_LW, T_SW:        return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic logic is_ld(input logic [3:0] op);
    return (op == T_LB) || (op == T_LH) || (op == T_LW) || (op == T_LBU) || (op == T_LHU);
  endfunction

  function automatic logic [3:0] ref_be(input logic [3:0] op, input logic [31:0] a);
    int n;
    n = op_bytes(op);
    if (is_ld(op) || n == 0) return 4'h0;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
    case (op_bytes(op))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      T_LB:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      T_LBU:   return b;
      T_LH:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      T_LHU:   return h;
      T_LW:    return rd;
      default: return 32'h0;
    endcase
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busywait", 32'(BUSYWAIT), 32'(exp_busy));
      chk("mem_read", 32'(MEM_READ), 32'(exp_read));
      chk("mem_write", 32'(MEM_WRITE), 32'(exp_write));
      chk("misaligned", 32'(MISALIGNED), 32'(exp_misal));
      chk("error", 32'(ERROR), 32'(exp_err));
      chk("load_data", LOAD_DATA, exp_load);
      if (exp_read || exp_write) begin
        chk("mem_address", MEM_ADDRESS, exp_addr);
        chk("mem_byte_en", 32'(MEM_BYTE_EN), 32'(exp_be));
      end
      if (exp_write) chk("mem_writedata", MEM_WRITEDATA, exp_wdata);
      if (BUSYWAIT)   busy_cycles++;
      if (MEM_READ)   read_cycles++;
      if (MISALIGNED) misal_cycles++;
      if (MEM_WRITE) begin
        write_cycles++;
        last_waddr = MEM_ADDRESS;
        last_wdata = MEM_WRITEDATA;
        last_be    = MEM_BYTE_EN;
      end
    end
  end

  // One pipeline op held in EX/MEM until it retires; nbusy = memory wait cycles.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] d2,
                       input logic [31:0] rd, input int nbusy);
    int n, acc;
    logic ld, mis, timed;
    n   = op_bytes(op);
    ld  = is_ld(op);
    mis = (n != 0) && ((addr % n) != 0);
    busy_cycles = 0; read_cycles = 0; write_cycles = 0; misal_cycles = 0;
    @(posedge CLK); #1;
    READ_WRITE = op; ALU_RESULT = addr; DATA2 = d2; MEM_READDATA = rd;
    MEM_BUSYWAIT = (nbusy > 0);
    exp_busy = (n != 0) && !mis; exp_read = 1'b0; exp_write = 1'b0; exp_misal = 1'b0;
    if (!exp_busy) begin
      @(posedge CLK); #1;
      READ_WRITE = T_NONE;
      exp_misal = mis;
    end else begin
      timed = (nbusy >= TO);
      acc   = timed ? TO : nbusy + 1;
      for (int i = 0; i < acc; i++) begin
        @(posedge CLK); #1;
        MEM_BUSYWAIT = (i < nbusy);
        exp_read  = ld;
        exp_write = !ld;
        exp_addr  = addr - (addr % 4);
        exp_be    = ref_be(op, addr);
        exp_wdata = ref_wdata(op, d2);
      end
      @(posedge CLK); #1;
      READ_WRITE = T_NONE; MEM_BUSYWAIT = 1'b0;
      exp_busy = 1'b0; exp_read = 1'b0; exp_write = 1'b0;
      if (timed) begin
        exp_load = 32'h0;
        exp_err  = 1'b1;
      end else if (ld) begin
        exp_load = ref_load(op, addr, rd);
      end
    end
    @(posedge CLK); #1;
    exp_misal = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; READ_WRITE = T_NONE; ALU_RESULT = 32'h0; DATA2 = 32'h0;
    MEM_READDATA = 32'h0; MEM_BUSYWAIT = 1'b0;
    #2 RESET = 1'b0;
    #1 chk_en = 1'b1;
    @(posedge CLK); #1;
    chk("rst_mem_address", MEM_ADDRESS, 32'h0);
    chk("rst_writedata", MEM_WRITEDATA, 32'h0);
    chk("rst_byte_en", 32'(MEM_BYTE_EN), 32'h0);
    chk("rst_load_data", LOAD_DATA, 32'h0);
    @(posedge CLK); #1;
    RESET = 1'b1;

    do_op(T_SW, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_busy_cycles", busy_cycles, 2);
    chk("sw_write_cycles", write_cycles, 1);
    chk("sw_addr", last_waddr, 32'h0000_0104);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);

    do_op(T_LB, 32'h0000_0203, 32'h0, 32'h80FF_1234, 3);
    chk("lb_busy_cycles", busy_cycles, 5);
    chk("lb_value", LOAD_DATA, 32'hFFFF_FF80);
    do_op(T_LBU, 32'h0000_0203, 32'h0, 32'h80FF_1234, 3);
    chk("lbu_value", LOAD_DATA, 32'h0000_0080);

    do_op(T_SH, 32'h0000_0102, 32'h0000_ABCD, 32'h0, 1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    do_op(T_LHU, 32'h0000_0102, 32'h0, 32'hABCD_0000, 0);
    chk("lhu_value", LOAD_DATA, 32'h0000_ABCD);
    do_op(T_LH, 32'h0000_0100, 32'h0, 32'h0000_8001, 2);
    chk("lh_value", LOAD_DATA, 32'hFFFF_8001);
    do_op(T_SB, 32'h0000_0001, 32'h0000_0055, 32'h0, 0);
    chk("sb_be", 32'(last_be), 32'h2);
    chk("sb_wdata", last_wdata, 32'h5555_5555);

    do_op(T_LW, 32'h0000_0101, 32'h0, 32'h1111_1111, 0);
    chk("lw_mis_pulses", misal_cycles, 1);
    chk("lw_mis_reads", read_cycles, 0);
    chk("lw_mis_busy", busy_cycles, 0);
    chk("lw_mis_load_kept", LOAD_DATA, 32'hFFFF_8001);
    do_op(T_SH, 32'h0000_0103, 32'h1234, 32'h0, 0);
    chk("sh_mis_pulses", misal_cycles, 1);
    do_op(4'b0011, 32'h0000_0000, 32'h0, 32'h0, 0);
    chk("illegal_busy", busy_cycles, 0);

    do_op(T_LW, 32'h0000_0200, 32'h0, 32'h1122_3344, 10);
    chk("to_read_cycles", read_cycles, TO);
    chk("to_error", 32'(ERROR), 32'h1);
    chk("to_load", LOAD_DATA, 32'h0);
    do_op(T_SW, 32'h0000_0008, 32'h0BAD_F00D, 32'h0, 0);
    do_op(T_LW, 32'h0000_000C, 32'h0, 32'hCAFE_F00D, 1);
    chk("err_sticky", 32'(ERROR), 32'h1);
    chk("lw_after_err", LOAD_DATA, 32'hCAFE_F00D);

    // Reset during the second ACCESS cycle of a load.
    @(posedge CLK); #1;
    READ_WRITE = T_LW; ALU_RESULT = 32'h0000_0400; MEM_READDATA = 32'h0000_0099;
    MEM_BUSYWAIT = 1'b1; exp_busy = 1'b1;
    @(posedge CLK); #1;
    exp_read = 1'b1; exp_addr = 32'h0000_0400; exp_be = 4'h0;
    @(posedge CLK); #1;
    #2 RESET = 1'b0;
    exp_busy = 1'b0; exp_read = 1'b0; exp_load = 32'h0; exp_err = 1'b0;
    #1;
    chk("rst_mid_read", 32'(MEM_READ), 32'h0);
    chk("rst_mid_busy", 32'(BUSYWAIT), 32'h0);
    chk("rst_mid_load", LOAD_DATA, 32'h0);
    @(posedge CLK); #1;
    READ_WRITE = T_NONE; MEM_BUSYWAIT = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    do_op(T_LW, 32'h0000_0300, 32'h0, 32'h1234_5678, 0);
    chk("post_rst_busy", busy_cycles, 2);
    chk("post_rst_load", LOAD_DATA, 32'h1234_5678);

    @(posedge CLK); #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
